instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  IF stage of the RV32IM 5-stage pipeline: owns the PC and drives instruction-memory reads over a
//  busywait handshake. Contains the IF/ID pipeline register; INSTRUCTION feeds the ID-stage decoder.
//  Honours a hazard STALL and an EX-stage BRANCH_TAKEN redirect, issuing bubbles when needed.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset.
//  NOP_INSTR  32'h0000_0013  Bubble encoding (ADDI x0,x0,0) driven on INSTRUCTION when invalid.
// PORTS
//  CLK            in   1   clock; all state updates on posedge
//  RESET          in   1   synchronous, active-high reset
//  STALL          in   1   hazard unit: hold IF/ID and PC
//  BRANCH_TAKEN   in   1   EX-stage redirect / flush request
//  BRANCH_TARGET  in   32  redirect PC; bits [1:0] forced to 2'b00
//  IMEM_READDATA  in   32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
//  IMEM_BUSYWAIT  in   1   memory not ready; request must be held stable
//  IMEM_READ      out  1   read request
//  IMEM_ADDRESS   out  32  read address
//  INSTRUCTION    out  32  IF/ID instruction to decoder
//  PC             out  32  IF/ID PC of INSTRUCTION
//  PC_PLUS_4      out  32  IF/ID PC+4 (link value for JAL/JALR)
//  INSTR_VALID    out  1   IF/ID valid; 0 = bubble
// BEHAVIOUR
//  - Reset (CLK-synchronous, active-high): pc_reg=RESET_PC, state=FETCH, INSTRUCTION=NOP_INSTR,
//    PC=PC_PLUS_4=0, INSTR_VALID=0. IMEM_READ forced 0 while RESET=1. Memory is reset in the same cycle.
//  - Accept = IMEM_READ & ~IMEM_BUSYWAIT. IMEM_READ/IMEM_ADDRESS are combinational from state and
//    never change while BUSYWAIT=1, except via RESET.
//  - FSM:
//    FETCH: IMEM_READ=1, IMEM_ADDRESS=pc_reg.
//           Accept & ~STALL -> IF/ID <= {pc_reg, data, valid=1}; pc_reg += 4.
//           Accept & STALL -> skid_buf <= data; go HOLD.
//    HOLD:  IMEM_READ=0. ~STALL -> IF/ID <= {pc_reg, skid_buf, valid=1}; pc_reg += 4; go FETCH.
//    DRAIN: IMEM_READ=1, IMEM_ADDRESS=drain_addr. Waits out an abandoned request.
//           Accept -> data discarded; go FETCH.
//  - Redirect (BRANCH_TAKEN=1) has priority over STALL and over accept.
//    IF/ID <= bubble. pc_reg <= {BRANCH_TARGET[31:2], 2'b00}. skid_buf is discarded.
//    Next state:
//      FETCH, BUSYWAIT=1  -> DRAIN (drain_addr <= pc_reg)
//      FETCH, accept cycle -> data dropped; stay FETCH
//      HOLD               -> FETCH
//      DRAIN, BUSYWAIT=1  -> stay DRAIN; target updated
//      DRAIN, accept cycle -> FETCH
//  - IF/ID update priority: RESET > BRANCH_TAKEN (bubble) > STALL (hold all) > HOLD-state release >
//    FETCH accept > otherwise bubble (NOP_INSTR, valid=0; PC/PC_PLUS_4 hold).
//  - STALL with no accept: pc_reg and IF/ID hold; the memory request continues.
//  - Latency: word at accept appears on INSTRUCTION the next edge.
//    Zero-wait memory sustains 1 instr/cycle.
//  - Arithmetic: pc_reg+4 and PC_PLUS_4 wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
// STRUCTURE
//  - Shared header pipeline_defs.vh: NOP_INSTR value, FSM state encodings (FETCH=2'd0, HOLD=2'd1,
//    DRAIN=2'd2), RESET_PC default.
//  - One sub-module: if_id_pipeline_reg (load/hold/bubble control, 97 bits). Reused by other
//    pipeline register stages.
//  - FSM, pc_reg, skid_buf and drain_addr live in the top level.
// TESTING
//  1 Reset then zero-wait mem: PCs 0,4,8 appear on PC with matching words; INSTR_VALID=1 from 2nd edge.
//  2 BUSYWAIT=1 3 cycles at addr 0x10: IMEM_ADDRESS stays 0x10; 3 bubbles (valid=0);
//    word arrives on 4th edge.
//  3 STALL=1 on accept of 0x20: IMEM_READ=0 in HOLD; IF/ID holds the previous instr.
//    STALL drop -> 0x20 word loads, next fetch 0x24.
//  4 BRANCH_TAKEN target 0x103 while BUSYWAIT=1 at 0x40: DRAIN keeps addr 0x40 until ready;
//    that word is dropped; next fetch is 0x100.
//  5 BRANCH_TAKEN and STALL same cycle: IF/ID becomes bubble; pc_reg=target.
//  6 pc_reg=0xFFFF_FFFC accepted: PC_PLUS_4=0, next IMEM_ADDRESS=0.
//    RESET mid-BUSYWAIT -> IMEM_READ=0, outputs at reset values.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage: bubble encoding, reset PC default,
// fetch FSM state encodings and the IF/ID pipeline register payload layout.
package instruction_fetch_unit_pkg;

  // ADDI x0,x0,0 -- architecturally a no-op, used as the bubble word.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Fetch FSM. The encodings are fixed so that other pipeline blocks and
  // debug tooling see the same values.
  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc_reg
    HOLD  = 2'd1,  // word captured in skid buffer, waiting for STALL to drop
    DRAIN = 2'd2   // waiting out a request abandoned by a redirect
  } fetch_state_e;

  // IF/ID pipeline register payload: 32 + 32 + 32 + 1 = 97 bits.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        valid;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // Instruction addresses are word aligned; the low two bits of any
  // redirect target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble control.
// Priority: reset > flush (bubble) > hold > load > bubble.
// A bubble replaces the instruction with NOP and clears valid, while the PC
// fields keep their last values so downstream debug views stay stable.
module if_id_pipeline_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               hold,
  input  logic               load,
  input  logic [IF_ID_W-1:0] d,
  output logic [IF_ID_W-1:0] q
);

  if_id_t d_s;
  if_id_t q_s;

  assign d_s = if_id_t'(d);
  assign q   = q_s;

  // Pipeline register update in priority order.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the values
    // present before the edge, independent of statement order.
    if (reset) begin
      q_s.instr     <= NOP_INSTR;
      q_s.pc        <= '0;
      q_s.pc_plus_4 <= '0;
      q_s.valid     <= 1'b0;
    end else if (flush) begin
      q_s.instr <= NOP_INSTR;
      q_s.valid <= 1'b0;
    end else if (hold) begin
      q_s <= q_s;
    end else if (load) begin
      q_s <= d_s;
    end else begin
      q_s.instr <= NOP_INSTR;
      q_s.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the RV32IM 5-stage pipeline. Owns the PC, issues
// instruction-memory reads over a busywait handshake and feeds the IF/ID
// register. A skid buffer absorbs a word that arrives while the pipeline is
// stalled; the DRAIN state waits out a request abandoned by a redirect, since
// the memory requires a request to be held stable until it completes.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        INSTR_VALID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  pc_plus_4;
  logic         accept;

  logic         ifid_flush;
  logic         ifid_hold;
  logic         ifid_load;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  // Wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  assign pc_plus_4 = pc_q + 32'd4;
  assign accept    = IMEM_READ & ~IMEM_BUSYWAIT;

  // Memory request: a pure function of state, so it cannot change while the
  // memory is busy; reset forces the request off.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    IMEM_READ    = 1'b0;
    IMEM_ADDRESS = pc_q;
    if (!RESET) begin
      unique case (state_q)
        FETCH: IMEM_READ = 1'b1;
        HOLD:  IMEM_READ = 1'b0;
        DRAIN: begin
          IMEM_READ    = 1'b1;
          IMEM_ADDRESS = drain_addr_q;
        end
        default: IMEM_READ = 1'b0;
      endcase
    end
  end

  // Next-state, PC and IF/ID control. A redirect outranks stall and accept.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    drain_addr_d = drain_addr_q;
    ifid_flush   = 1'b0;
    ifid_hold    = 1'b0;
    ifid_load    = 1'b0;
    ifid_d.instr     = IMEM_READDATA;
    ifid_d.pc        = pc_q;
    ifid_d.pc_plus_4 = pc_plus_4;
    ifid_d.valid     = 1'b1;

    if (BRANCH_TAKEN) begin
      ifid_flush = 1'b1;
      pc_d       = align_word(BRANCH_TARGET);
      unique case (state_q)
        FETCH: begin
          // An unfinished request must still complete at its old address.
          if (!accept) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        HOLD:    state_d = FETCH;
        DRAIN:   if (accept) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (accept && STALL) begin
            skid_d    = IMEM_READDATA;
            state_d   = HOLD;
            ifid_hold = 1'b1;
          end else if (accept) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus_4;
          end else begin
            ifid_hold = STALL;
          end
        end
        HOLD: begin
          if (STALL) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_d.instr = skid_q;
            ifid_load    = 1'b1;
            pc_d         = pc_plus_4;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          // The drained word belongs to the abandoned path and is dropped.
          ifid_hold = STALL;
          if (accept) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM, PC, skid buffer and drain address registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_q       <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  if_id_pipeline_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk   (CLK),
    .reset (RESET),
    .flush (ifid_flush),
    .hold  (ifid_hold),
    .load  (ifid_load),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign INSTRUCTION = ifid_q.instr;
  assign PC          = ifid_q.pc;
  assign PC_PLUS_4   = ifid_q.pc_plus_4;
  assign INSTR_VALID = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by a random
// phase, all compared against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        INSTR_VALID;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  assign IMEM_READDATA = IMEM_BUSYWAIT ? 32'hDEAD_BEEF : mem_word(IMEM_ADDRESS);

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .INSTRUCTION   (INSTRUCTION),
    .PC            (PC),
    .PC_PLUS_4     (PC_PLUS_4),
    .INSTR_VALID   (INSTR_VALID)
  );

  // Reference model: next PC to deliver, a captured-but-undelivered word,
  // an abandoned request still owed by memory, and the expected IF/ID view.
  logic [31:0] m_pc;
  logic        m_pending;
  logic [31:0] m_skid;
  logic        m_drain;
  logic [31:0] m_drain_addr;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid();
    check("instruction", INSTRUCTION, e_instr);
    check("pc",          PC,          e_pc);
    check("pc_plus_4",   PC_PLUS_4,   e_pc4);
    check("instr_valid", {31'b0, INSTR_VALID}, {31'b0, e_valid});
  endtask

  task automatic bubble();
    e_instr = NOP;
    e_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] word);
    e_instr = word;
    e_pc    = m_pc;
    e_pc4   = m_pc + 32'd4;
    e_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
  endtask

  task automatic do_reset(input logic bw);
    RESET         = 1'b1;
    STALL         = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = '0;
    IMEM_BUSYWAIT = bw;
    #1;
    check("reset_imem_read", {31'b0, IMEM_READ}, 32'd0);
    @(posedge CLK);
    #1;
    m_pc = 32'h0; m_pending = 1'b0; m_drain = 1'b0; m_skid = '0; m_drain_addr = '0;
    e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;
    check_ifid();
    RESET = 1'b0;
  endtask

  // One clock cycle with the given inputs, checked before and after the edge.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt, input logic bw);
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        got;
    STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt; IMEM_BUSYWAIT = bw;
    #1;
    exp_read = !m_pending;
    exp_addr = m_drain ? m_drain_addr : m_pc;
    check("imem_read", {31'b0, IMEM_READ}, {31'b0, exp_read});
    if (exp_read) check("imem_address", IMEM_ADDRESS, exp_addr);
    got = exp_read && !bw;

    if (br) begin
      bubble();
      if (!m_pending && !m_drain && !got) begin
        m_drain      = 1'b1;
        m_drain_addr = m_pc;
      end else if (m_drain && got) begin
        m_drain = 1'b0;
      end
      m_pending = 1'b0;
      m_pc      = tgt & 32'hFFFF_FFFC;
    end else if (st) begin
      if (m_drain && got) m_drain = 1'b0;
      else if (!m_drain && !m_pending && got) begin
        m_pending = 1'b1;
        m_skid    = mem_word(exp_addr);
      end
    end else if (m_pending) begin
      deliver(m_skid);
      m_pending = 1'b0;
    end else if (m_drain) begin
      bubble();
      if (got) m_drain = 1'b0;
    end else if (got) begin
      deliver(mem_word(exp_addr));
    end else begin
      bubble();
    end

    @(posedge CLK);
    #1;
    check_ifid();
  endtask

  initial begin
    // 1: reset, then zero-wait fetches of 0, 4, 8.
    do_reset(1'b0);
    check("t1_reset_instr", INSTRUCTION, NOP);
    step(0, 0, 0, 0);
    check("t1_first_valid", {31'b0, INSTR_VALID}, 32'd1);
    check("t1_first_pc", PC, 32'h0);
    check("t1_first_word", INSTRUCTION, mem_word(32'h0));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t1_third_pc", PC, 32'h8);

    // 2: three wait cycles at 0x10.
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    check("t2_bubble", {31'b0, INSTR_VALID}, 32'd0);
    step(0, 0, 0, 0);
    check("t2_word_pc", PC, 32'h10);

    // 3: stall on the accept of 0x20.
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t3_hold_prev", PC, 32'h1C);
    step(1, 0, 0, 0);
    check("t3_hold_read", {31'b0, IMEM_READ}, 32'd0);
    step(0, 0, 0, 0);
    check("t3_release_pc", PC, 32'h20);
    check("t3_release_word", INSTRUCTION, mem_word(32'h20));
    step(0, 0, 0, 0);
    check("t3_next_pc", PC, 32'h24);

    // 4: redirect to 0x103 while the fetch at 0x40 is busy.
    step(0, 1, 32'h40, 0);
    step(0, 1, 32'h103, 1);
    step(0, 0, 0, 1);
    check("t4_drain_addr", IMEM_ADDRESS, 32'h40);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("t4_drop", {31'b0, INSTR_VALID}, 32'd0);
    step(0, 0, 0, 0);
    check("t4_target_pc", PC, 32'h100);

    // 5: redirect and stall in the same cycle.
    step(1, 1, 32'h200, 0);
    check("t5_bubble", {31'b0, INSTR_VALID}, 32'd0);
    step(0, 0, 0, 0);
    check("t5_target_pc", PC, 32'h200);

    // 6: PC wrap, then reset in the middle of a busy request.
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    check("t6_wrap_pc", PC, 32'hFFFF_FFFC);
    check("t6_wrap_pc4", PC_PLUS_4, 32'h0);
    step(0, 0, 0, 0);
    check("t6_wrapped_pc", PC, 32'h0);
    step(0, 0, 0, 1);
    do_reset(1'b1);
    check("t6_reset_valid", {31'b0, INSTR_VALID}, 32'd0);
    step(0, 0, 0, 0);
    check("t6_after_reset_pc", PC, 32'h0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset(1'($urandom_range(1)));
      end else begin
        step(1'($urandom_range(3) == 0),
             1'($urandom_range(9) == 0),
             $urandom,
             1'($urandom_range(9) < 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
